booth_mul_ctrl: RTL and testbench

Sequential radix-2 Booth signed multiplier: a control FSM sequencing a register/adder datapath of accumulator A, multiplier Q, Q(-1) bit, multiplicand M and an iteration counter. It sits beside the existing register, counter and adder utilities as the first full arithmetic unit. Operations use a start/done handshake, and the result is held in an output register.

---
 rtl/booth_pkg.sv | 28 ++
 rtl/booth_mul_dp.sv | 91 +++++++++
 rtl/booth_mul_ctrl.sv | 156 +++++++++++++++
 tb/tb_booth_mul_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-2 Booth multiplier.
//   state_t     : 2-bit control state encoding (IDLE, ADD, SHIFT, DONE)
//   PAIR_*      : values of the examined bit pair {Q[0], Q(-1)}
//   is_nop_pair : true when the pair asks for neither add nor subtract
// -----------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Booth recoding of {Q[0], Q(-1)}
   localparam logic [1:0] PAIR_NOP0 = 2'b00;
   localparam logic [1:0] PAIR_ADD  = 2'b01;
   localparam logic [1:0] PAIR_SUB  = 2'b10;
   localparam logic [1:0] PAIR_NOP1 = 2'b11;

   // A pair of equal bits sits inside a run of 0s or 1s: nothing to add.
   function automatic logic is_nop_pair(input logic [1:0] pair);
      return (pair == PAIR_NOP0) || (pair == PAIR_NOP1);
   endfunction

endpackage

// File: rtl/booth_mul_dp.sv
// -----------------------------------------------------------------------------
// booth_mul_dp
// Register/adder datapath of the Booth multiplier. Holds the accumulator A
// (W+1 bits), multiplier Q, the Q(-1) bit, multiplicand M and the iteration
// counter. Everything it does is commanded by one-hot-ish strobes from the
// controller; when several are high the priority is cl > load > add > sub >
// shift (the controller never raises more than one of load/add/sub/shift).
//
// Ports
//   clk, rst_b  : clock, asynchronous active-low reset
//   cl          : synchronous clear of every register
//   load        : capture x into M, y into Q; zero A, Q(-1), cnt
//   add / sub   : A <= A + M  /  A <= A - M  (M sign-extended to W+1 bits)
//   shift       : arithmetic right shift of {A,Q,Q(-1)}, cnt <= cnt + 1
//   x, y        : operands, two's complement
//   pair        : {Q[0], Q(-1)} for the controller's Booth decision
//   last        : cnt has reached W-1, i.e. the coming shift is the final one
//   result_sh   : {A,Q} as it will look after one more shift, low 2W bits;
//                 lets the controller register the product on the final shift
// -----------------------------------------------------------------------------
module booth_mul_dp
   import booth_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             cl,
   input  logic             load,
   input  logic             add,
   input  logic             sub,
   input  logic             shift,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   output logic [1:0]       pair,
   output logic             last,
   output logic [2*W-1:0]   result_sh
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

   logic [W:0]       a;
   logic [W-1:0]     m;
   logic [W-1:0]     q;
   logic             q_m1;
   logic [CNT_W-1:0] cnt;
   logic [W:0]       m_ext;

   // A is one bit wider than M so that A - M with M = -2^(W-1) stays in range.
   assign m_ext = {m[W-1], m};

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         a    <= '0;
         m    <= '0;
         q    <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (cl) begin
         a    <= '0;
         m    <= '0;
         q    <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         a    <= '0;
         m    <= x;
         q    <= y;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (add) begin
         a <= a + m_ext;
      end else if (sub) begin
         a <= a - m_ext;
      end else if (shift) begin
         a    <= {a[W], a[W:1]};
         q    <= {a[0], q[W-1:1]};
         q_m1 <= q[0];
         cnt  <= cnt + 1'b1;
      end
   end

   assign pair = {q[0], q_m1};
   assign last = (cnt == LAST_CNT);

   // After a shift, A[W-1:0] becomes old A[W:1] and Q becomes {A[0], Q[W-1:1]};
   // concatenated that is simply {A, Q[W-1:1]}.
   assign result_sh = {a, q[W-1:1]};

endmodule

// File: rtl/booth_mul_ctrl.sv
// -----------------------------------------------------------------------------
// booth_mul_ctrl
// Sequential radix-2 Booth signed multiplier: control FSM, done/busy flags and
// the product register, around the booth_mul_dp datapath.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in IDLE
// accepts x/y and the unit turns busy. Exactly one cycle with done=1 follows the
// final shift, with product valid from that cycle until the next completion,
// cl or reset. start is ignored while busy (including the DONE cycle).
//
// Ports
//   clk, rst_b  : clock, asynchronous active-low reset
//   start       : request a multiply (sampled in IDLE only)
//   cl          : synchronous clear/abort, beats start; no done pulse
//   x, y        : multiplicand and multiplier, signed W bits
//   product     : signed 2W-bit result register
//   busy        : high in ADD, SHIFT and DONE
//   done        : one-cycle completion pulse
//   state       : current FSM state, for observation
//
// Build option BOOTH_SKIP_EN: when defined, an ADD step whose pair is 00/11
// shifts in the same cycle instead of visiting SHIFT, giving a data-dependent
// latency of W..2W edges from acceptance to DONE. Results are unchanged.
// -----------------------------------------------------------------------------
module booth_mul_ctrl
   import booth_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W) + 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             cl,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   output logic [2*W-1:0]   product,
   output logic             busy,
   output logic             done,
   output state_t           state
);

   logic [1:0]     pair;
   logic           last;
   logic [2*W-1:0] result_sh;

   logic load_en;
   logic add_en;
   logic sub_en;
   logic shift_en;
   logic skip;
   logic finish;

`ifdef BOOTH_SKIP_EN
   assign skip = is_nop_pair(pair);
`else
   assign skip = 1'b0;
`endif

   // Datapath strobes are decoded from the current state so they act on the
   // same edge as the state transition they belong to. cl masks them all.
   always_comb begin
      load_en  = 1'b0;
      add_en   = 1'b0;
      sub_en   = 1'b0;
      shift_en = 1'b0;
      if (!cl) begin
         case (state)
            IDLE:  load_en  = start;
            ADD: begin
               add_en   = (pair == PAIR_ADD);
               sub_en   = (pair == PAIR_SUB);
               shift_en = skip;
            end
            SHIFT: shift_en = 1'b1;
            default: ;
         endcase
      end
   end

   // The final shift is the one taken while cnt == W-1.
   assign finish = shift_en && last;

   booth_mul_dp #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk       (clk),
      .rst_b     (rst_b),
      .cl        (cl),
      .load      (load_en),
      .add       (add_en),
      .sub       (sub_en),
      .shift     (shift_en),
      .x         (x),
      .y         (y),
      .pair      (pair),
      .last      (last),
      .result_sh (result_sh)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else if (cl) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= ADD;
                  busy  <= 1'b1;
               end
            end
            ADD: begin
               if (finish) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  product <= result_sh;
               end else if (skip) begin
                  state <= ADD;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (finish) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  product <= result_sh;
               end else begin
                  state <= ADD;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_ctrl
// Self-checking bench for booth_mul_ctrl (W=8). The driver issues operations
// and pushes the expected product and completion cycle into queues; a monitor
// pops and compares whenever done is seen. Expected values come from signed
// multiplication and a per-bit count of Booth iterations.
// -----------------------------------------------------------------------------
module tb_booth_mul_ctrl;
   import booth_pkg::*;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_b = 1'b0;
   logic           start = 1'b0;
   logic           cl = 1'b0;
   logic [W-1:0]   x = '0;
   logic [W-1:0]   y = '0;
   logic [2*W-1:0] product;
   logic           busy;
   logic           done;
   state_t         state;

   booth_mul_ctrl #(.W(W)) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .start   (start),
      .cl      (cl),
      .x       (x),
      .y       (y),
      .product (product),
      .busy    (busy),
      .done    (done),
      .state   (state)
   );

   // ---------------- clock / reset -----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end expected end of test");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard -----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W-1:0] exp_q[$];
   int unsigned    exp_cyc_q[$];
   logic [2*W-1:0] held = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model -----------------
   function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   // Edges from acceptance to the edge that enters DONE.
   function automatic int unsigned ref_latency(input logic [W-1:0] b);
      int unsigned l;
      logic [W:0]  bb;
      bb = {b, 1'b0};
      l = 0;
      for (int i = 0; i < W; i++) begin
`ifdef BOOTH_SKIP_EN
         l += (bb[i+1] == bb[i]) ? 1 : 2;
`else
         l += 2;
`endif
      end
      return l;
   endfunction

   // ---------------- monitor -----------------
   always @(negedge clk) begin
      if (rst_b && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [2*W-1:0] e;
            int unsigned    c;
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            check("product", product, e);
            check("done_cycle", cyc, c);
            check("busy_with_done", busy, 1);
         end
      end
   end

   // ---------------- driver tasks -----------------
   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", busy, 0);
   endtask

   // Issue one operation; returns at the negedge after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
      wait_idle();
      start = 1'b1;
      x = a;
      y = b;
      @(posedge clk);
      #1;
      if (expect_done) begin
         exp_q.push_back(ref_product(a, b));
         exp_cyc_q.push_back(cyc + ref_latency(b));
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("product_hold", product, held);
      if (expect_done) held = ref_product(a, b);
   endtask

   // ---------------- stimulus -----------------
   initial begin
      logic [W-1:0] da[7];
      logic [W-1:0] db[7];
      int unsigned  n0;
      int unsigned  l0;

      da = '{8'd3, 8'hFD, 8'd127, 8'h80, 8'd0, 8'hFF, 8'd2};
      db = '{8'd5, 8'd5,  8'h80,  8'h80, 8'd0, 8'hFF, 8'd3};

      // reset state
      #12;
      check("rst_product", product, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state, IDLE);
      @(negedge clk);
      rst_b = 1'b1;

      // directed operands, including the -128 * -128 overflow case
      for (int i = 0; i < 7; i++) issue(da[i], db[i], 1'b1);

      // start re-pulsed mid-operation is ignored
      issue(8'd7, 8'd9, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1;
      x = 8'd1;
      y = 8'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("restart_ignored", product, 16'h003F);

      // cl mid-operation: abort, clear product, no done
      issue(8'd10, 8'd11, 1'b0);
      repeat (4) @(negedge clk);
      cl = 1'b1;
      @(negedge clk);
      cl = 1'b0;
      check("cl_busy", busy, 0);
      check("cl_done", done, 0);
      check("cl_product", product, 0);
      check("cl_state", state, IDLE);
      held = '0;

      // cl beats start in IDLE
      start = 1'b1;
      cl = 1'b1;
      @(negedge clk);
      check("cl_over_start", busy, 0);
      start = 1'b0;
      cl = 1'b0;

      // async reset mid-operation
      issue(8'd2, 8'd3, 1'b1);
      issue(8'd5, 8'd6, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      check("arst_product", product, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_state", state, IDLE);
      @(negedge clk);
      rst_b = 1'b1;
      held = '0;

      // start held high: second op accepted on the first IDLE edge after DONE
      wait_idle();
      start = 1'b1;
      x = 8'hE9;
      y = 8'h35;
      @(posedge clk);
      #1;
      n0 = cyc;
      l0 = ref_latency(8'h35);
      exp_q.push_back(ref_product(8'hE9, 8'h35));
      exp_cyc_q.push_back(n0 + l0);
      exp_q.push_back(ref_product(8'hE9, 8'h35));
      exp_cyc_q.push_back(n0 + l0 + 2 + l0);
      repeat (l0 + 2) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      held = ref_product(8'hE9, 8'h35);

      // random operands
      for (int i = 0; i < 40; i++) begin
         issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b1);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("final_product", product, held);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
